// File: rtl/adder_operand_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adder_seq_pkg
//  Purpose : Shared types and default sizes for the adder operand sequencer.
//            - seq_state_t : sequencer FSM state encoding (2 bits)
//            - WIDTH_DEF   : default operand width (sum is WIDTH+1 bits)
//            - CNT_W_DEF   : default width of the completed-transaction counter
//  Revision: 1.0  initial release
// ============================================================================
package adder_seq_pkg;

  localparam int WIDTH_DEF = 6;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } seq_state_t;

endpackage : adder_seq_pkg
`default_nettype wire

// File: rtl/adder_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module  : adder_operand_sequencer_if
//  Purpose : Operand input stream and result output stream of the sequencer.
//            in_valid/in_ready/in_data    : serial operand beats (A then B)
//            out_valid/out_ready/out_data : registered WIDTH+1 bit sum
//            modport slave  : the sequencer side
//            modport master : the producer/consumer side (environment)
//  Revision: 1.0  initial release
// ============================================================================
interface adder_operand_sequencer_if
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface : adder_operand_sequencer_if
`default_nettype wire

// File: rtl/adder_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : adder_operand_sequencer
//  Purpose : Collects two operands serially over a valid/ready input, holds
//            them on a_out/b_out for an external combinational adder, captures
//            the adder's sum one cycle later and returns it over a valid/ready
//            output. Counts completed output handshakes.
//  Ports   : clock     - rising-edge clock
//            reset     - asynchronous active-low reset
//            io        - operand/result streams (slave modport)
//            a_out     - operand A to the adder
//            b_out     - operand B to the adder
//            sum_in    - adder result, combinational from a_out/b_out
//            busy      - high in any state other than LOAD_A
//            txn_count - completed output handshakes, wraps to 0
//  Revision: 1.0  initial release
// ============================================================================
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  wire logic             clock,
  input  wire logic             reset,
  adder_operand_sequencer_if.slave io,
  output      logic [WIDTH-1:0] a_out,
  output      logic [WIDTH-1:0] b_out,
  input  wire logic [WIDTH:0]   sum_in,
  output      logic             busy,
  output      logic [CNT_W-1:0] txn_count
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_out_data;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_txn_count;
  logic             w_in_ready;
  logic             w_busy;

  // in_ready depends only on state, so there is no combinational path from
  // in_valid. In SEND out_valid is always 1, so out_ready alone completes
  // the handshake.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      LOAD_A: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (io.in_valid) w_next_state = LOAD_B;
      end
      LOAD_B: begin
        w_in_ready = 1'b1;
        if (io.in_valid) w_next_state = CAPTURE;
      end
      CAPTURE: begin
        w_next_state = SEND;
      end
      SEND: begin
        // A new A is only taken from the cycle after the result leaves.
        if (io.out_ready) w_next_state = LOAD_A;
      end
      default: begin
        w_next_state = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= LOAD_A;
      r_a         <= '0;
      r_b         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_txn_count <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        LOAD_A: if (io.in_valid) r_a <= io.in_data;
        LOAD_B: if (io.in_valid) r_b <= io.in_data;
        CAPTURE: begin
          // Operands have been stable for a full cycle; sum_in has settled.
          r_out_data  <= sum_in;
          r_out_valid <= 1'b1;
        end
        SEND: begin
          if (io.out_ready) begin
            r_out_valid <= 1'b0;
            r_txn_count <= r_txn_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = r_out_valid;
  assign io.out_data  = r_out_data;
  assign a_out        = r_a;
  assign b_out        = r_b;
  assign busy         = w_busy;
  assign txn_count    = r_txn_count;

endmodule : adder_operand_sequencer
`default_nettype wire

// File: tb/tb_adder_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adder_operand_sequencer
//  Purpose : Self-checking bench for adder_operand_sequencer with the 6-bit
//            adder modelled beside it. Directed steps followed by randomized
//            transactions; expected sums, latency and counts come from a
//            transaction-level reference model kept in the bench.
//  Revision: 1.0  initial release
// ============================================================================
module tb_adder_operand_sequencer;

  localparam int WIDTH = 6;
  localparam int CNT_W = 8;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH:0]   sum_in;
  logic             busy;
  logic [CNT_W-1:0] txn_count;

  int n_cmp;
  int n_err;

  // Reference model state: transactions completed since reset, last operands.
  int exp_cnt;
  int exp_a;
  int exp_b;

  adder_operand_sequencer_if #(.WIDTH(WIDTH)) io ();

  adder_operand_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .io        (io.slave),
    .a_out     (a_out),
    .b_out     (b_out),
    .sum_in    (sum_in),
    .busy      (busy),
    .txn_count (txn_count)
  );

  // The example adder: zero-extended combinational sum.
  assign sum_in = {1'b0, a_out} + {1'b0, b_out};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one operand beat starting at a falling edge; returns at the
  // falling edge after it was accepted, with in_valid dropped.
  task automatic beat(input string tag, input logic [WIDTH-1:0] d);
    logic got;
    io.in_valid = 1'b1;
    io.in_data  = d;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (io.in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!got) check({tag, "_ready_timeout"}, 32'(got), 32'd1);
    @(negedge clock);
    io.in_valid = 1'b0;
  endtask

  // Full transaction: A, B, capture, SEND held for 'stall' cycles with
  // out_ready low, then release. During the last SEND cycle in_valid is
  // driven high to confirm no A is accepted in SEND.
  task automatic txn(input string tag, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input int stall);
    logic [WIDTH:0] held;
    io.out_ready = 1'b0;
    beat({tag, "_a"}, a);
    exp_a = int'(a);
    check({tag, "_a_out"}, 32'(a_out), 32'(exp_a));
    check({tag, "_busy_b"}, 32'(busy), 32'd1);
    beat({tag, "_b"}, b);
    exp_b = int'(b);
    check({tag, "_b_out"}, 32'(b_out), 32'(exp_b));
    // CAPTURE cycle: result not yet visible, input closed.
    check({tag, "_cap_ovalid"}, 32'(io.out_valid), 32'd0);
    check({tag, "_cap_iready"}, 32'(io.in_ready), 32'd0);
    io.out_ready = (stall == 0);
    @(negedge clock);
    check({tag, "_ovalid"}, 32'(io.out_valid), 32'd1);
    check({tag, "_sum"}, 32'(io.out_data), 32'(exp_a + exp_b));
    check({tag, "_send_iready"}, 32'(io.in_ready), 32'd0);
    held = io.out_data;
    for (int i = 0; i < stall; i++) begin
      io.in_valid = 1'($urandom_range(0, 1));
      io.in_data  = WIDTH'($urandom_range(0, 63));
      @(negedge clock);
      check({tag, "_stall_ovalid"}, 32'(io.out_valid), 32'd1);
      check({tag, "_stall_data"}, 32'(io.out_data), 32'(held));
      check({tag, "_stall_cnt"}, 32'(txn_count), 32'(exp_cnt % 256));
    end
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    io.in_data   = WIDTH'(~a);
    @(negedge clock);
    io.in_valid  = 1'b0;
    exp_cnt++;
    check({tag, "_done_ovalid"}, 32'(io.out_valid), 32'd0);
    check({tag, "_done_iready"}, 32'(io.in_ready), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_no_overlap_a"}, 32'(a_out), 32'(exp_a));
    check({tag, "_cnt"}, 32'(txn_count), 32'(exp_cnt % 256));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ovalid"}, 32'(io.out_valid), 32'd0);
    check({tag, "_iready"}, 32'(io.in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cnt"}, 32'(txn_count), 32'd0);
    check({tag, "_a_out"}, 32'(a_out), 32'd0);
    check({tag, "_b_out"}, 32'(b_out), 32'd0);
    check({tag, "_odata"}, 32'(io.out_data), 32'd0);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    exp_cnt      = 0;
    exp_a        = 0;
    exp_b        = 0;
    reset        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;

    // Reset, then idle.
    repeat (3) @(negedge clock);
    check_reset_values("rst_in");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("rst_idle");

    // Basic transaction and back-to-back pair.
    txn("t1_1", 6'd1, 6'd1, 0);
    txn("t1_4", 6'd1, 6'd4, 0);
    txn("t4_1", 6'd4, 6'd1, 0);

    // Maximum operands with a 5-cycle stall.
    txn("tmax", 6'd63, 6'd63, 5);
    txn("tzero", 6'd0, 6'd0, 1);

    // Reset in LOAD_B after A=10: everything returns to reset values.
    beat("rmid_a", 6'd10);
    check("rmid_a_out", 32'(a_out), 32'd10);
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    check_reset_values("rmid");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("rmid_rel");
    txn("t2_3", 6'd2, 6'd3, 0);

    // Randomized transactions, total 256 since reset -> counter wraps.
    for (int k = 0; k < 255; k++) begin
      txn("rnd", WIDTH'($urandom_range(0, 63)), WIDTH'($urandom_range(0, 63)),
          int'($urandom_range(0, 3)));
    end
    check("wrap_cnt", 32'(txn_count), 32'd0);
    check("wrap_model", 32'(exp_cnt), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_adder_operand_sequencer
`default_nettype wire
